// File: rtl/self_trig_ext.sv
// Per-channel self trigger: polarity-selectable threshold discriminator with
// hysteresis, crossing prescaler, programmable trigger delay, holdoff and counters.
module self_trig_ext #(
    parameter int unsigned ABITS   = 12,
    parameter int unsigned CBITS   = 10,
    parameter int unsigned DELBITS = 4,
    parameter int unsigned HBITS   = 8
) (
    input  logic               adcclk,
    input  logic               reset,
    input  logic signed [15:0] data,
    input  logic               inhibit,
    input  logic               polarity,
    input  logic [ABITS-1:0]   threshold,
    input  logic [1:0]         hyst,
    input  logic [15:0]        prescale,
    input  logic [DELBITS-1:0] delay,
    input  logic [HBITS-1:0]   holdoff,
    output logic               trig,
    output logic               busy,
    output logic [CBITS-1:0]   counter,
    output logic [CBITS-1:0]   raw_counter
);

    // Comparison width: wide enough for the sample and a zero-extended threshold
    localparam int unsigned CW = ((ABITS > 16) ? ABITS : 16) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_HOLD
    } state_e;

    state_e             state_q, state_d;
    logic               inh_q;
    logic signed [15:0] s_q, s_d;
    logic               discr_q, discr_d;
    logic [15:0]        presc_q, presc_d;
    logic [CBITS-1:0]   cnt_q, cnt_d;
    logic [CBITS-1:0]   raw_q, raw_d;
    logic [DELBITS-1:0] dcnt_q, dcnt_d;
    logic [HBITS-1:0]   hcnt_q, hcnt_d;
    logic               trig_q, trig_d;
    logic               busy_q, busy_d;

    logic signed [CW-1:0] s_ext_c, thr_ext_c, rel_ext_c;
    logic                 cross_c, release_c, start_c;

    assign s_ext_c   = {{(CW-16){s_q[15]}}, s_q};
    assign thr_ext_c = CW'(threshold);
    assign rel_ext_c = CW'(threshold >> hyst);

    assign cross_c   = !inh_q && !discr_q && (s_ext_c > thr_ext_c);
    assign release_c = !inh_q && (s_ext_c <= rel_ext_c);
    assign start_c   = cross_c && (presc_q == '0) && !busy_q;

    // Polarity flip; negating the most negative sample saturates
    always_comb begin
        s_d = data;
        if (polarity) begin
            s_d = (data == 16'sh8000) ? 16'sh7fff : -data;
        end
    end

    always_comb begin
        state_d = state_q;
        discr_d = discr_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        raw_d   = raw_q;
        dcnt_d  = dcnt_q;
        hcnt_d  = hcnt_q;
        trig_d  = 1'b0;

        if (inh_q) begin
            discr_d = 1'b0;
            state_d = S_IDLE;
            dcnt_d  = '0;
            hcnt_d  = '0;
        end else begin
            if (cross_c) begin
                discr_d = 1'b1;
                raw_d   = raw_q + CBITS'(1);
                if (presc_q != '0) begin
                    presc_d = presc_q - 16'd1;
                end else begin
                    presc_d = prescale;
                    cnt_d   = cnt_q + CBITS'(1);
                end
            end else if (release_c) begin
                discr_d = 1'b0;
            end

            // A selected crossing while busy is counted but never queued
            case (state_q)
                S_IDLE: begin
                    if (start_c) begin
                        state_d = S_DELAY;
                        dcnt_d  = delay;
                    end
                end
                S_DELAY: begin
                    if (dcnt_q == '0) begin
                        trig_d  = 1'b1;
                        state_d = S_HOLD;
                        hcnt_d  = holdoff;
                    end else begin
                        dcnt_d = dcnt_q - DELBITS'(1);
                    end
                end
                S_HOLD: begin
                    if (hcnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        hcnt_d = hcnt_q - HBITS'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge adcclk) begin
        if (reset) begin
            state_q <= S_IDLE;
            inh_q   <= 1'b1;
            s_q     <= '0;
            discr_q <= 1'b0;
            presc_q <= '0;
            cnt_q   <= '0;
            raw_q   <= '0;
            dcnt_q  <= '0;
            hcnt_q  <= '0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inh_q   <= inhibit;
            s_q     <= s_d;
            discr_q <= discr_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            raw_q   <= raw_d;
            dcnt_q  <= dcnt_d;
            hcnt_q  <= hcnt_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
        end
    end

    assign trig        = trig_q;
    assign busy        = busy_q;
    assign counter     = cnt_q;
    assign raw_counter = raw_q;

endmodule

// File: tb/tb_self_trig_ext.sv
// Bench for self_trig_ext: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against an event-time reference model.
module tb_self_trig_ext;

    logic        adcclk = 1'b0;
    logic        reset;
    logic [15:0] data;
    logic        inhibit;
    logic        polarity;
    logic [11:0] threshold;
    logic [1:0]  hyst;
    logic [15:0] prescale;
    logic [3:0]  delay;
    logic [7:0]  holdoff;
    logic        trig;
    logic        busy;
    logic [9:0]  counter;
    logic [9:0]  raw_counter;

    int n_cmp = 0;
    int n_err = 0;

    self_trig_ext dut (
        .adcclk     (adcclk),
        .reset      (reset),
        .data       (data),
        .inhibit    (inhibit),
        .polarity   (polarity),
        .threshold  (threshold),
        .hyst       (hyst),
        .prescale   (prescale),
        .delay      (delay),
        .holdoff    (holdoff),
        .trig       (trig),
        .busy       (busy),
        .counter    (counter),
        .raw_counter(raw_counter)
    );

    always #5 adcclk = ~adcclk;

    // Reference model: trigger and dead time tracked as absolute cycle numbers
    int cyc = 0;
    int m_inh, m_s, m_discr, m_presc, m_cnt, m_raw;
    int m_trig_at, m_busy_end, m_trig, m_busy;

    task automatic model_step();
        int thr, rel, v, busy_prev;
        cyc++;
        busy_prev = m_busy;
        if (reset) begin
            m_inh = 1; m_s = 0; m_discr = 0; m_presc = 0; m_cnt = 0; m_raw = 0;
            m_trig_at = -1; m_busy_end = -1;
        end else begin
            if (m_inh != 0) begin
                m_discr = 0; m_trig_at = -1; m_busy_end = -1;
            end else begin
                if (m_trig_at == cyc) m_busy_end = cyc + int'(holdoff);
                thr = int'(threshold);
                rel = int'(threshold) / (1 << hyst);
                if (m_s > thr && m_discr == 0) begin
                    m_discr = 1;
                    m_raw = (m_raw + 1) % 1024;
                    if (m_presc != 0) m_presc--;
                    else begin
                        m_presc = int'(prescale);
                        m_cnt = (m_cnt + 1) % 1024;
                        if (busy_prev == 0) m_trig_at = cyc + 1 + int'(delay);
                    end
                end else if (m_s <= rel) begin
                    m_discr = 0;
                end
            end
            m_inh = int'(inhibit);
            v = int'($signed(data));
            if (polarity) v = -v;
            if (v > 32767) v = 32767;
            m_s = v;
        end
        m_trig = (m_trig_at == cyc) ? 1 : 0;
        m_busy = (m_trig_at >= cyc || m_busy_end >= cyc) ? 1 : 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge adcclk);
        model_step();
        #1;
        check("model_trig", int'(trig), m_trig);
        check("model_busy", int'(busy), m_busy);
        check("model_counter", int'(counter), m_cnt);
        check("model_raw", int'(raw_counter), m_raw);
    endtask

    task automatic do_reset();
        reset = 1'b1; inhibit = 1'b0; data = '0;
        tick();
        check("rst_trig", int'(trig), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_counter", int'(counter), 0);
        check("rst_raw", int'(raw_counter), 0);
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic set_cfg(input bit pol, input int thr, input int hy, input int ps,
                           input int dl, input int ho);
        polarity = pol; threshold = 12'(thr); hyst = 2'(hy);
        prescale = 16'(ps); delay = 4'(dl); holdoff = 8'(ho);
    endtask

    // Single-sample pulse; trig is checked exactly lat edges after the sample edge
    task automatic pulse(input int v, input int lat, input bit exp);
        data = 16'(v);
        tick();
        data = '0;
        for (int i = 1; i < lat; i++) tick();
        tick();
        check("pulse_trig", int'(trig), int'(exp));
        for (int i = 0; i < 60 && busy; i++) tick();
        tick(); tick();
    endtask

    typedef struct {
        logic [15:0] din;
        logic        inh;
        int          e_trig;
        int          e_busy;
        int          e_cnt;
        int          e_raw;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic trigger then hysteresis: thr=100, hyst=1 -> release at 50
        tbl[0]  = '{16'd200, 1'b0, 0, 0, 0, 0};
        tbl[1]  = '{16'd0,   1'b0, 0, 1, 1, 1};
        tbl[2]  = '{16'd0,   1'b0, 1, 1, 1, 1};
        tbl[3]  = '{16'd0,   1'b0, 0, 0, 1, 1};
        tbl[4]  = '{16'd150, 1'b0, 0, 0, 1, 1};
        tbl[5]  = '{16'd60,  1'b0, 0, 1, 2, 2};
        tbl[6]  = '{16'd150, 1'b0, 1, 1, 2, 2};
        tbl[7]  = '{16'd40,  1'b0, 0, 0, 2, 2};
        tbl[8]  = '{16'd150, 1'b0, 0, 0, 2, 2};
        tbl[9]  = '{16'd0,   1'b0, 0, 1, 3, 3};
        tbl[10] = '{16'd0,   1'b0, 1, 1, 3, 3};
        tbl[11] = '{16'd0,   1'b0, 0, 0, 3, 3};

        reset = 1'b1; inhibit = 1'b0; data = '0;
        set_cfg(1'b0, 100, 1, 0, 0, 0);
        m_busy = 0; m_trig_at = -1; m_busy_end = -1;
        do_reset();
        foreach (tbl[k]) begin
            data = tbl[k].din; inhibit = tbl[k].inh;
            tick();
            check("tbl_trig", int'(trig), tbl[k].e_trig);
            check("tbl_busy", int'(busy), tbl[k].e_busy);
            check("tbl_counter", int'(counter), tbl[k].e_cnt);
            check("tbl_raw", int'(raw_counter), tbl[k].e_raw);
        end

        // Prescale 1-of-3 with delay 5: pulses 1 and 4 trigger at 7 clocks
        set_cfg(1'b0, 100, 1, 2, 5, 0);
        do_reset();
        for (int p = 0; p < 5; p++) pulse(300, 7, (p == 0 || p == 3));
        check("presc_counter", int'(counter), 2);
        check("presc_raw", int'(raw_counter), 5);

        // Negative polarity, saturation of -32768, positive pulse ignored
        set_cfg(1'b1, 100, 1, 0, 0, 0);
        do_reset();
        pulse(-200, 2, 1'b1);
        pulse(-32768, 2, 1'b1);
        pulse(200, 2, 1'b0);
        check("neg_counter", int'(counter), 2);

        // Holdoff 20: second pulse dropped, third (30 clocks later) triggers
        set_cfg(1'b0, 100, 1, 0, 0, 20);
        do_reset();
        for (int i = 0; i <= 40; i++) begin
            data = (i == 0 || i == 10 || i == 30) ? 16'd300 : 16'd0;
            tick();
            check("hold_trig", int'(trig), (i == 2 || i == 32) ? 1 : 0);
            check("hold_busy", int'(busy), ((i >= 1 && i <= 22) || i >= 31) ? 1 : 0);
        end
        check("hold_counter", int'(counter), 3);
        check("hold_raw", int'(raw_counter), 3);

        // Inhibit while a delayed trigger is pending
        set_cfg(1'b0, 100, 1, 0, 10, 0);
        do_reset();
        data = 16'd300; tick();
        data = '0; tick(); tick(); tick();
        check("inh_pending_busy", int'(busy), 1);
        inhibit = 1'b1; tick();
        tick();
        check("inh_busy", int'(busy), 0);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("inh_trig", int'(trig), 0);
        end
        inhibit = 1'b0; tick(); tick();
        check("inh_counter", int'(counter), 1);
        check("inh_raw", int'(raw_counter), 1);

        // Reset mid-stream with a trigger pending
        set_cfg(1'b0, 100, 1, 0, 3, 5);
        data = 16'd300; tick();
        data = '0; tick(); tick();
        reset = 1'b1; tick();
        check("midrst_trig", int'(trig), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_counter", int'(counter), 0);
        check("midrst_raw", int'(raw_counter), 0);
        reset = 1'b0; tick();

        // Counter wrap at 2^10
        set_cfg(1'b0, 100, 1, 0, 0, 0);
        do_reset();
        for (int p = 0; p < 1023; p++) begin
            data = 16'd300; tick();
            data = '0; tick(); tick(); tick();
        end
        check("wrap_pre_counter", int'(counter), 1023);
        check("wrap_pre_raw", int'(raw_counter), 1023);
        pulse(300, 2, 1'b1);
        check("wrap_counter", int'(counter), 0);
        check("wrap_raw", int'(raw_counter), 0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 63) == 0)
                set_cfg(1'($urandom_range(0, 1)), int'($urandom_range(0, 600)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 15)), int'($urandom_range(0, 12)));
            case ($urandom_range(0, 3))
                0: data = '0;
                1: data = 16'($urandom());
                2: data = 16'($urandom_range(0, 700));
                default: data = 16'(-int'($urandom_range(0, 700)));
            endcase
            if ($urandom_range(0, 99) == 0) inhibit = ~inhibit;
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
